// File: rtl/block_reorder_buffer.sv
// Multi-bank NxN block buffer; each stored block is read back either as stored or transposed.
// Optional build macro BLOCK_REORDER_CHECK_EN adds a sticky sob/eob protocol error output.
module block_reorder_buffer #(
    parameter int W_IO  = 16,
    parameter int N     = 8,
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N*W_IO-1:0] in_data,
    input  logic              in_sob,
    input  logic              in_eob,
    input  logic              in_sof,
    input  logic              in_trps,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N*W_IO-1:0] out_data,
    output logic              out_sob,
    output logic              out_eob,
    output logic              out_sof
`ifdef BLOCK_REORDER_CHECK_EN
    ,
    output logic              err
`endif
);

    localparam int RW = $clog2(N);
    localparam int PW = $clog2(DEPTH);
    localparam logic [RW-1:0] ROW_LAST = RW'(N - 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

    logic [N*W_IO-1:0] mem [DEPTH][N];
    logic [DEPTH-1:0]  full;
    logic [DEPTH-1:0]  trps_f;
    logic [DEPTH-1:0]  sof_f;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [RW-1:0]     wr_row;
    logic [RW-1:0]     rd_row;
    logic              in_hs;
    logic              out_hs;
    logic [N*W_IO-1:0] row_raw;
    logic [N*W_IO-1:0] row_t;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // A bank stays full from its last written row until its last row is read.
    assign in_ready  = en & ~rst & ~full[wr_ptr];
    assign out_valid = en & ~rst & full[rd_ptr];
    assign in_hs     = in_valid & in_ready;
    assign out_hs    = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full   <= '0;
            trps_f <= '0;
            sof_f  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            wr_row <= '0;
            rd_row <= '0;
        end else if (en) begin
            if (in_hs) begin
                if (wr_row == '0) begin
                    trps_f[wr_ptr] <= in_trps;
                    sof_f[wr_ptr]  <= in_sof;
                end
                if (wr_row == ROW_LAST) begin
                    wr_row       <= '0;
                    full[wr_ptr] <= 1'b1;
                    wr_ptr       <= next_ptr(wr_ptr);
                end else begin
                    wr_row <= wr_row + 1'b1;
                end
            end
            if (out_hs) begin
                if (rd_row == ROW_LAST) begin
                    rd_row       <= '0;
                    full[rd_ptr] <= 1'b0;
                    rd_ptr       <= next_ptr(rd_ptr);
                end else begin
                    rd_row <= rd_row + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (in_hs) begin
            mem[wr_ptr][wr_row] <= in_data;
        end
    end

    // Transposed row r gathers element r from every stored row of the bank.
    always_comb begin
        row_raw = mem[rd_ptr][rd_row];
        row_t   = '0;
        for (int c = 0; c < N; c++) begin
            row_t[c*W_IO +: W_IO] = mem[rd_ptr][RW'(c)][int'(rd_row)*W_IO +: W_IO];
        end
        out_data = '0;
        if (out_valid) begin
            out_data = trps_f[rd_ptr] ? row_t : row_raw;
        end
    end

    assign out_sob = out_valid & (rd_row == '0);
    assign out_eob = out_valid & (rd_row == ROW_LAST);
    assign out_sof = out_sob & sof_f[rd_ptr];

`ifdef BLOCK_REORDER_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (in_hs && ((in_sob != (wr_row == '0)) || (in_eob != (wr_row == ROW_LAST)))) begin
            err <= 1'b1;
        end
    end
`else
    logic unused_markers;
    assign unused_markers = in_sob ^ in_eob;
`endif

endmodule

// File: tb/tb_block_reorder_buffer.sv
// Directed bench for block_reorder_buffer (N=8, W_IO=16, DEPTH=2); checks err when built with BLOCK_REORDER_CHECK_EN.
module tb_block_reorder_buffer;
    localparam int W     = 16;
    localparam int N     = 8;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst, en, in_valid, in_ready, in_sob, in_eob, in_sof, in_trps;
    logic out_valid, out_ready, out_sob, out_eob, out_sof;
    logic [N*W-1:0] in_data, out_data;
`ifdef BLOCK_REORDER_CHECK_EN
    logic err;
`endif

    int total = 0;
    int bad   = 0;

    block_reorder_buffer #(.W_IO(W), .N(N), .DEPTH(DEPTH)) u_dut (
        .clk(clk), .rst(rst), .en(en),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sob(in_sob), .in_eob(in_eob), .in_sof(in_sof), .in_trps(in_trps),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sob(out_sob), .out_eob(out_eob), .out_sof(out_sof)
`ifdef BLOCK_REORDER_CHECK_EN
        , .err(err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int   base;
        logic trps;
        logic sof;
    } blk_t;

    task automatic chk(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Row r of a block with the given base; trps selects the transposed view.
    function automatic logic [N*W-1:0] mk_row(input int base, input int r, input logic trps);
        logic [N*W-1:0] v;
        logic [W-1:0]   e;
        v = '0;
        for (int c = 0; c < N; c++) begin
            e = W'(base + (trps ? 16*c + r : 16*r + c));
            v[c*W +: W] = e;
        end
        return v;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic put_row(input int base, input int r, input logic trps, input logic sof,
                           input logic sob, input logic eob);
        int n;
        in_valid = 1'b1;
        in_data  = mk_row(base, r, 1'b0);
        in_sob   = sob;
        in_eob   = eob;
        in_sof   = sof;
        in_trps  = trps;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL in_ready_timeout: got 0 want 1 (row %0d)", r);
        end
        tick();
        in_valid = 1'b0;
        in_sob   = 1'b0;
        in_eob   = 1'b0;
        in_sof   = 1'b0;
        in_trps  = 1'b0;
    endtask

    task automatic put_block(input int base, input logic trps, input logic sof);
        for (int r = 0; r < N; r++)
            put_row(base, r, trps, sof && (r == 0), r == 0, r == N-1);
    endtask

    task automatic get_block(input string name, input int base, input logic trps, input logic sof);
        out_ready = 1'b1;
        for (int r = 0; r < N; r++) begin
            chk({name, "_valid"}, out_valid, 1'b1);
            chk({name, "_data"}, out_data, mk_row(base, r, trps));
            chk({name, "_sob"}, out_sob, r == 0);
            chk({name, "_eob"}, out_eob, r == N-1);
            chk({name, "_sof"}, out_sof, sof && (r == 0));
            tick();
        end
        out_ready = 1'b0;
    endtask

    blk_t vec[5];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec[0] = '{base: 'h000, trps: 1'b0, sof: 1'b1};
        vec[1] = '{base: 'h100, trps: 1'b1, sof: 1'b0};
        vec[2] = '{base: 'h200, trps: 1'b0, sof: 1'b0};
        vec[3] = '{base: 'h300, trps: 1'b1, sof: 1'b0};
        vec[4] = '{base: 'h400, trps: 1'b0, sof: 1'b0};

        rst = 1'b1; en = 1'b1; in_valid = 1'b0; in_data = '0; in_sob = 1'b0;
        in_eob = 1'b0; in_sof = 1'b0; in_trps = 1'b0; out_ready = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, '0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("idle_in_ready", in_ready, 1'b1);
        chk("idle_out_valid", out_valid, 1'b0);
        chk("idle_out_data", out_data, '0);

        // Table: one block at a time, latency and content per block, pointers wrap twice.
        for (int i = 0; i < 5; i++) begin
            for (int r = 0; r < N-1; r++)
                put_row(vec[i].base, r, vec[i].trps, vec[i].sof && (r == 0), r == 0, 1'b0);
            chk("lat_pre_valid", out_valid, 1'b0);
            put_row(vec[i].base, N-1, vec[i].trps, 1'b0, 1'b0, 1'b1);
            chk("lat_post_valid", out_valid, 1'b1);
            get_block("tbl", vec[i].base, vec[i].trps, vec[i].sof);
            chk("tbl_drained", out_valid, 1'b0);
        end

        // Transposed block followed back-to-back by an untransposed one.
        put_block('h010, 1'b1, 1'b0);
        put_block('h020, 1'b0, 1'b0);
        get_block("b2b_t", 'h010, 1'b1, 1'b0);
        get_block("b2b_n", 'h020, 1'b0, 1'b0);

        // Backpressure: both banks full, in_ready returns right after the last read.
        put_block('h030, 1'b0, 1'b0);
        put_block('h040, 1'b1, 1'b0);
        chk("full_in_ready", in_ready, 1'b0);
        out_ready = 1'b1;
        for (int r = 0; r < N; r++) begin
            chk("bp_data", out_data, mk_row('h030, r, 1'b0));
            chk("bp_in_ready_low", in_ready, 1'b0);
            tick();
        end
        out_ready = 1'b0;
        chk("bp_in_ready_back", in_ready, 1'b1);
        put_block('h050, 1'b0, 1'b0);
        get_block("bp_b", 'h040, 1'b1, 1'b0);
        get_block("bp_c", 'h050, 1'b0, 1'b0);

        // Last-row write into one bank coincides with last-row read from the other.
        put_block('h060, 1'b0, 1'b0);
        fork
            put_block('h070, 1'b1, 1'b0);
            get_block("sim_a", 'h060, 1'b0, 1'b0);
        join
        get_block("sim_b", 'h070, 1'b1, 1'b0);

        // Enable low freezes everything and hides the stored block.
        put_block('h080, 1'b1, 1'b1);
        en = 1'b0;
        #1;
        chk("en_out_valid", out_valid, 1'b0);
        chk("en_in_ready", in_ready, 1'b0);
        chk("en_out_data", out_data, '0);
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        en = 1'b1;
        #1;
        get_block("en_blk", 'h080, 1'b1, 1'b1);

`ifdef BLOCK_REORDER_CHECK_EN
        chk("err_clean", err, 1'b0);
        for (int r = 0; r < N; r++) begin
            put_row('h090, r, 1'b0, 1'b0, r == 0, (r == 5) || (r == N-1));
            if (r == 4) chk("err_pre", err, 1'b0);
            if (r == 5) chk("err_set", err, 1'b1);
        end
        chk("err_sticky", err, 1'b1);
        get_block("err_blk", 'h090, 1'b0, 1'b0);
        chk("err_hold", err, 1'b1);
`endif

        // Reset in the middle of a block with one block already stored.
        put_block('h0a0, 1'b0, 1'b0);
        for (int r = 0; r < 4; r++)
            put_row('h0b0, r, 1'b0, 1'b0, r == 0, 1'b0);
        chk("mid_valid_before", out_valid, 1'b1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_data", out_data, '0);
        chk("mid_rst_sob", out_sob, 1'b0);
        chk("mid_rst_in_ready", in_ready, 1'b0);
`ifdef BLOCK_REORDER_CHECK_EN
        chk("mid_rst_err", err, 1'b0);
`endif
        @(negedge clk);
        rst = 1'b0;
        tick();
        for (int r = 0; r < N-1; r++)
            put_row('h0c0, r, 1'b0, 1'b0, r == 0, 1'b0);
        chk("post_rst_pre_valid", out_valid, 1'b0);
        put_row('h0c0, N-1, 1'b0, 1'b0, 1'b0, 1'b1);
        get_block("post_rst", 'h0c0, 1'b0, 1'b0);
        chk("final_valid", out_valid, 1'b0);
        chk("final_data", out_data, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/block_reorder_buffer.md
BLOCK_REORDER_BUFFER -- requirements
Module: block_reorder_buffer

Interface
REQ-001 SHALL have parameters: W_IO, default 16, coefficient width in bits; N, default 8, block dimension (rows = cols), power of 2 in 2..16; DEPTH, default 2, number of block banks in 2..4.
REQ-002 SHALL have ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  global enable; low freezes all state.
- in_valid  input  1  input row valid.
- in_ready  output  1  input row accepted when in_valid&in_ready.
- in_data  input  N*W_IO  row, element c at bits [c*W_IO +: W_IO].
- in_sob  input  1  start-of-block marker.
- in_eob  input  1  end-of-block marker.
- in_sof  input  1  start-of-frame marker.
- in_trps  input  1  transpose request for the block.
- out_valid  output  1  output row valid.
- out_ready  input  1  output row consumed when out_valid&out_ready.
- out_data  output  N*W_IO  output row.
- out_sob  output  1  first row of block.
- out_eob  output  1  last row of block.
- out_sof  output  1  block starts a frame.
- err  output  1  sticky protocol error; present only with BLOCK_REORDER_CHECK_EN.

Function
REQ-003 SHALL store up to DEPTH complete NxN blocks in banks used round-robin; write and read pointers wrap DEPTH-1 -> 0.
REQ-004 The write row counter ($clog2(N) bits) SHALL increment on each input handshake; block is complete on the handshake at row N-1, then counter returns to 0 and write pointer advances.
REQ-005 SHALL sample in_trps and in_sof on row 0 of each block into per-bank flags.
REQ-006 in_ready SHALL be en & (write bank not holding an unread or draining block); derived from registered state only, no combinational path from out_ready or in_valid.
REQ-007 out_valid SHALL be en & (read bank holds a complete block); first row presented the cycle after the final input handshake of that block (latency 1 cycle).
REQ-008 Output row r SHALL equal stored row r when the bank trps flag is 0; element c of row r SHALL equal element r of stored row c when trps flag is 1.
REQ-009 out_sob SHALL be out_valid & (read row == 0); out_eob SHALL be out_valid & (read row == N-1); out_sof SHALL be out_sob & bank sof flag.
REQ-010 Read row counter SHALL advance on output handshake; on handshake at row N-1 the bank is freed and read pointer advances.
REQ-011 A bank freed in cycle t SHALL be writable from cycle t+1; simultaneous last-row write into one bank and last-row read from another SHALL both complete.
REQ-012 With all DEPTH banks occupied in_ready SHALL be 0; with no complete block out_valid SHALL be 0 and out_data SHALL be 0.
REQ-013 out_valid & ~out_ready SHALL hold out_data and all markers stable.
REQ-014 en low SHALL force in_ready=0, out_valid=0 and freeze counters, pointers and flags.

Reset
REQ-015 rst high SHALL immediately clear all banks to empty, pointers and row counters to 0, flags to 0, err to 0; out_valid, in_ready, out_sob, out_eob, out_sof = 0 and out_data = 0.
REQ-016 Storage array contents SHALL NOT be reset; partial blocks in progress at reset SHALL be discarded.

Configuration
REQ-017 With BLOCK_REORDER_CHECK_EN defined, err SHALL set (sticky until rst) on any accepted row with in_sob=1 at row≠0, in_sob=0 at row 0, in_eob=1 at row≠N-1, or in_eob=0 at row N-1; data flow is unaffected.
REQ-018 Without BLOCK_REORDER_CHECK_EN, port err SHALL be absent, and in_sob/in_eob SHALL be ignored; row count alone delimits blocks.

Verification (N=8, W_IO=16, DEPTH=2 unless stated)
REQ-019 Block of element value 16*r+c, trps=0, out_ready=1 -> out_valid 1 cycle after row 7; row r element c = 16*r+c; out_sob at row 0, out_eob at row 7.
REQ-020 Same block with trps=1 -> output row r element c = 16*c+r; next block trps=0 follows untransposed back-to-back.
REQ-021 Three blocks streamed, out_ready=0 -> in_ready drops after the 16th row; raising out_ready for 8 rows -> in_ready returns the cycle after row 7 is read; all 24 rows out in order.
REQ-022 in_sof=1 on block 0 row 0 only, DEPTH=4 -> out_sof=1 solely with block 0 out_sob; pointers wrap 3->0 on block 4 without loss.
REQ-023 rst pulsed mid-block at row 4 with one block stored -> outputs 0 immediately; next 8 rows form a fresh block output correctly.
REQ-024 With BLOCK_REORDER_CHECK_EN, in_eob=1 at row 5 -> err=1 next cycle, stays 1; data still output as 8-row block.
